// File: rtl/memory_interface_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Sequences IDLE -> ACCESS -> RELEASE per transaction and times out reads that never complete.
module memory_interface_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDRESS_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instruction_memory_interface_enable,
    input  logic [ADDRESS_WIDTH-1:0] instruction_memory_interface_address,
    output logic                     instruction_memory_interface_ready,
    output logic [31:0]              instruction_memory_interface_data,
    input  logic                     data_memory_interface_enable,
    input  logic                     data_memory_interface_state,
    input  logic [ADDRESS_WIDTH-1:0] data_memory_interface_address,
    input  logic [3:0]               data_memory_interface_frame_mask,
    input  logic [31:0]              data_memory_interface_write_data,
    output logic                     data_memory_interface_ready,
    output logic [31:0]              data_memory_interface_read_data,
    output logic                     memory_enable,
    output logic                     memory_state,
    output logic [ADDRESS_WIDTH-1:0] memory_address,
    output logic [3:0]               memory_frame_mask,
    output logic [31:0]              memory_write_data,
    input  logic [31:0]              memory_read_data,
    input  logic                     memory_ready,
    output logic                     bus_error
);

    typedef enum logic [1:0] {StIdle, StAccess, StRelease} state_e;

    state_e      r_state;
    logic        r_last_grant_data;
    logic        r_grant_data;
    logic [31:0] r_count;

    logic        w_pick_instr;
    logic        w_write_done;
    logic        w_read_done;
    logic        w_timeout_hit;
    logic        w_finish;
    logic [31:0] w_read_word;

    // Instruction wins unless data is also pending and instruction was served last.
    assign w_pick_instr  = instruction_memory_interface_enable &&
                           (!data_memory_interface_enable || r_last_grant_data);
    assign w_write_done  = memory_state;
    assign w_read_done   = !memory_state && memory_ready;
    assign w_timeout_hit = !memory_state && !memory_ready && (TIMEOUT_CYCLES != 0) &&
                           ((r_count + 32'd1) >= TIMEOUT_CYCLES);
    assign w_finish      = w_write_done || w_read_done || w_timeout_hit;
    assign w_read_word   = w_read_done ? memory_read_data : 32'h0000_0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state                            <= StIdle;
            r_last_grant_data                  <= 1'b1;
            r_grant_data                       <= 1'b0;
            r_count                            <= 32'd0;
            instruction_memory_interface_ready <= 1'b0;
            instruction_memory_interface_data  <= 32'h0;
            data_memory_interface_ready        <= 1'b0;
            data_memory_interface_read_data    <= 32'h0;
            memory_enable                      <= 1'b0;
            memory_state                       <= 1'b0;
            memory_address                     <= '0;
            memory_frame_mask                  <= 4'b0000;
            memory_write_data                  <= 32'h0;
            bus_error                          <= 1'b0;
        end else begin
            instruction_memory_interface_ready <= 1'b0;
            data_memory_interface_ready        <= 1'b0;
            bus_error                          <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (instruction_memory_interface_enable || data_memory_interface_enable) begin
                        r_grant_data  <= !w_pick_instr;
                        r_count       <= 32'd0;
                        memory_enable <= 1'b1;
                        r_state       <= StAccess;
                        if (w_pick_instr) begin
                            memory_address    <= instruction_memory_interface_address;
                            memory_state      <= 1'b0;
                            memory_frame_mask <= 4'b1111;
                            memory_write_data <= 32'h0;
                        end else begin
                            memory_address    <= data_memory_interface_address;
                            memory_state      <= data_memory_interface_state;
                            memory_frame_mask <= data_memory_interface_frame_mask;
                            memory_write_data <= data_memory_interface_write_data;
                        end
                    end
                end
                StAccess: begin
                    if (w_finish) begin
                        memory_enable <= 1'b0;
                        bus_error     <= w_timeout_hit;
                        r_state       <= StRelease;
                        if (r_grant_data) begin
                            data_memory_interface_ready <= 1'b1;
                            if (!memory_state) begin
                                data_memory_interface_read_data <= w_read_word;
                            end
                        end else begin
                            instruction_memory_interface_ready <= 1'b1;
                            instruction_memory_interface_data  <= w_read_word;
                        end
                    end else begin
                        r_count <= r_count + 32'd1;
                    end
                end
                StRelease: begin
                    r_last_grant_data <= r_grant_data;
                    r_count           <= 32'd0;
                    r_state           <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_interface_arbiter.sv
// Directed bench for memory_interface_arbiter: per-cycle check against a transaction model
// plus literal expectations for each scenario.
module tb_memory_interface_arbiter;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ien = 1'b0;
    logic [31:0] iaddr = 32'h0;
    logic        iready;
    logic [31:0] idata;
    logic        den = 1'b0;
    logic        dstate = 1'b0;
    logic [31:0] daddr = 32'h0;
    logic [3:0]  dmask = 4'h0;
    logic [31:0] dwdata = 32'h0;
    logic        dready;
    logic [31:0] drdata;
    logic        men;
    logic        mstate;
    logic [31:0] maddr;
    logic [3:0]  mmask;
    logic [31:0] mwdata;
    logic [31:0] mrdata = 32'h0;
    logic        mready;
    logic        berr;

    logic        resp_ready = 1'b0;
    logic        stray_ready = 1'b0;
    assign mready = resp_ready | stray_ready;

    memory_interface_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .ADDRESS_WIDTH (32)
    ) dut (
        .clk                                 (clk),
        .reset                               (reset),
        .instruction_memory_interface_enable (ien),
        .instruction_memory_interface_address(iaddr),
        .instruction_memory_interface_ready  (iready),
        .instruction_memory_interface_data   (idata),
        .data_memory_interface_enable        (den),
        .data_memory_interface_state         (dstate),
        .data_memory_interface_address       (daddr),
        .data_memory_interface_frame_mask    (dmask),
        .data_memory_interface_write_data    (dwdata),
        .data_memory_interface_ready         (dready),
        .data_memory_interface_read_data     (drdata),
        .memory_enable                       (men),
        .memory_state                        (mstate),
        .memory_address                      (maddr),
        .memory_frame_mask                   (mmask),
        .memory_write_data                   (mwdata),
        .memory_read_data                    (mrdata),
        .memory_ready                        (mready),
        .bus_error                           (berr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: answers a read on its mem_delay-th ACCESS cycle (0 = never).
    int          mem_delay = 0;
    logic [31:0] mem_word = 32'h0;
    int          acc_cnt = 0;
    always @(negedge clk) begin
        if (men === 1'b1 && mstate === 1'b0) begin
            acc_cnt = acc_cnt + 1;
            if (mem_delay > 0 && acc_cnt == mem_delay) begin
                resp_ready = 1'b1;
                mrdata     = mem_word;
            end else begin
                resp_ready = 1'b0;
            end
        end else begin
            acc_cnt    = 0;
            resp_ready = 1'b0;
        end
    end

    // Transaction model: who owns the port, how long it has waited, and the expected outputs.
    int          m_owner = 0;  // 0 none, 1 instruction, 2 data
    bit          m_release = 1'b0;
    bit          m_last_data = 1'b1;
    int          m_wait = 0;
    logic        e_men, e_mst, e_ir, e_dr, e_be;
    logic [31:0] e_maddr, e_mwd, e_id, e_dd, m_word;
    logic [3:0]  e_mmask;

    always @(posedge clk) begin
        if (reset) begin
            m_owner = 0; m_release = 1'b0; m_last_data = 1'b1; m_wait = 0;
            e_men = 0; e_mst = 0; e_maddr = 0; e_mmask = 0; e_mwd = 0;
            e_ir = 0; e_id = 0; e_dr = 0; e_dd = 0; e_be = 0;
        end else begin
            e_ir = 0; e_dr = 0; e_be = 0;
            if (m_release) begin
                m_last_data = (m_owner == 2);
                m_owner     = 0;
                m_release   = 1'b0;
            end else if (m_owner == 0) begin
                if (ien && (!den || m_last_data)) begin
                    m_owner = 1; e_maddr = iaddr; e_mst = 0; e_mmask = 4'hF; e_mwd = 0;
                end else if (den) begin
                    m_owner = 2; e_maddr = daddr; e_mst = dstate; e_mmask = dmask; e_mwd = dwdata;
                end
                if (m_owner != 0) begin
                    e_men  = 1;
                    m_wait = 0;
                end
            end else begin
                m_wait++;
                if (e_mst || mready || (TO > 0 && m_wait >= int'(TO))) begin
                    m_word    = (!e_mst && mready) ? mrdata : 32'h0;
                    e_men     = 0;
                    m_release = 1'b1;
                    e_be      = !e_mst && !mready;
                    if (m_owner == 1) begin
                        e_ir = 1; e_id = m_word;
                    end else begin
                        e_dr = 1;
                        if (!e_mst) e_dd = m_word;
                    end
                end
            end
        end
    end

    // Per-cycle compare and activity monitor.
    bit          chk_en = 1'b0;
    int          run = 0, last_run = 0, n_runs = 0, n_ip = 0, n_dp = 0;
    logic [3:0]  mon_mask = 4'h0;
    logic        mon_state = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("memory_enable", men, e_men);
            check("memory_state", mstate, e_mst);
            check("memory_address", maddr, e_maddr);
            check("memory_frame_mask", mmask, e_mmask);
            check("memory_write_data", mwdata, e_mwd);
            check("instr_ready", iready, e_ir);
            check("instr_data", idata, e_id);
            check("data_ready", dready, e_dr);
            check("data_read_data", drdata, e_dd);
            check("bus_error", berr, e_be);
            check("one_ready", iready & dready, 1'b0);
            if (men) begin
                run++;
                mon_mask  = mmask;
                mon_state = mstate;
            end else if (run > 0) begin
                last_run = run;
                n_runs++;
                run = 0;
            end
            if (iready) n_ip++;
            if (dready) n_dp++;
        end
    end

    task automatic wait_ready(output int who, output logic be);
        who = 0;
        be  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (iready) begin who = 1; be = berr; break; end
            if (dready) begin who = 2; be = berr; break; end
        end
        #1;
    endtask

    int   who;
    logic be;
    int   order[4];
    int   runs0, ip0, dp0;

    initial begin
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("reset_men", men, 1'b0);
        check("reset_addr", maddr, 32'h0);

        // Single fetch, memory answers on the 4th ACCESS cycle.
        mem_delay = 4; mem_word = 32'h0051_3023;
        ien = 1'b1; iaddr = 32'h0000_0010;
        wait_ready(who, be);
        check("fetch_who", who, 1);
        check("fetch_data", idata, 32'h0051_3023);
        check("fetch_addr", maddr, 32'h0000_0010);
        check("fetch_access_len", last_run, 4);
        ien = 1'b0;

        // Data store: exactly one ACCESS cycle, no memory_ready needed.
        mem_delay = 0;
        den = 1'b1; dstate = 1'b1; daddr = 32'h0000_0100; dmask = 4'b0011; dwdata = 32'hDEAD_BEEF;
        wait_ready(who, be);
        check("store_who", who, 2);
        check("store_access_len", last_run, 1);
        check("store_mask", mon_mask, 4'b0011);
        check("store_state", mon_state, 1'b1);
        den = 1'b0; dstate = 1'b0;
        @(negedge clk);

        // Contention straight out of reset: instruction first, then alternate.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        runs0 = n_runs;
        mem_delay = 1; mem_word = 32'hA5A5_0001;
        ien = 1'b1; iaddr = 32'h0000_0200;
        den = 1'b1; dstate = 1'b0; daddr = 32'h0000_0300; dmask = 4'hF; dwdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            wait_ready(who, be);
            order[k] = who;
        end
        ien = 1'b0; den = 1'b0;
        check("cont_grant0", order[0], 1);
        check("cont_grant1", order[1], 2);
        check("cont_grant2", order[2], 1);
        check("cont_grant3", order[3], 2);
        check("cont_enable_runs", n_runs - runs0, 4);
        check("cont_drdata", drdata, 32'hA5A5_0001);

        // Read timeout: memory never answers.
        mem_delay = 0;
        den = 1'b1; dstate = 1'b0; daddr = 32'h0000_0400; dmask = 4'hF;
        wait_ready(who, be);
        check("to_who", who, 2);
        check("to_bus_error", be, 1'b1);
        check("to_data", drdata, 32'h0);
        check("to_access_len", last_run, 16);
        den = 1'b0;
        mem_delay = 2; mem_word = 32'h1234_5678;
        ien = 1'b1; iaddr = 32'h0000_0020;
        wait_ready(who, be);
        check("post_to_who", who, 1);
        check("post_to_bus_error", be, 1'b0);
        check("post_to_data", idata, 32'h1234_5678);
        ien = 1'b0;
        @(negedge clk);

        // Reset during the third ACCESS cycle of a read.
        mem_delay = 0;
        den = 1'b1; daddr = 32'h0000_0500;
        for (int i = 0; i < 20 && men !== 1'b1; i++) @(negedge clk);
        check("midrst_started", men, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        ip0 = n_ip; dp0 = n_dp;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; den = 1'b0;
        check("midrst_men", men, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        check("midrst_no_dready", n_dp, dp0);
        check("midrst_no_iready", n_ip, ip0);
        mem_delay = 1; mem_word = 32'hCAFE_0003;
        ien = 1'b1; iaddr = 32'h0000_0030;
        wait_ready(who, be);
        check("midrst_fetch_who", who, 1);
        check("midrst_fetch_data", idata, 32'hCAFE_0003);
        ien = 1'b0;
        @(negedge clk);

        // Stray memory_ready while idle.
        #1;
        ip0 = n_ip; dp0 = n_dp; runs0 = n_runs;
        stray_ready = 1'b1;
        @(negedge clk);
        stray_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("stray_iready", n_ip, ip0);
        check("stray_dready", n_dp, dp0);
        check("stray_no_access", n_runs, runs0);
        check("stray_men", men, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
